serial_adder_32: RTL and testbench
==================================

# serial_adder_32

Bit-serial modular adder that computes `op_a + op_b + cin` one bit per clock, LSB first. Each bit position goes through a single full-adder slice with a registered carry. It is the sequential stage wrapped around the team's full-adder cell and produces the 32-bit mod-2^32 sums used by the hash datapath. It trades throughput for area, and it uses a simple start/busy/done handshake toward the hash round controller.

## Interface

Parameters:
- `WIDTH`, default 32: operand and sum width in bits; must be ≥ 2.

Ports (reset is synchronous, active-low, sampled on the rising edge of `clk`):
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `reset_L`  in  1  synchronous active-low reset.
- `start`  in  1  request a new addition; sampled in IDLE only.
- `op_a`  in  WIDTH  addend A; captured on the accepted `start`.
- `op_b`  in  WIDTH  addend B; captured on the accepted `start`.
- `cin`  in  1  carry-in; captured on the accepted `start`.
- `busy`  out  1  high while bits are being processed (RUN state).
- `done`  out  1  one-cycle pulse: `sum` and `cout` have just updated.
- `sum`  out  WIDTH  result, mod 2^WIDTH; held until the next completion.
- `cout`  out  1  carry out of bit WIDTH-1; held with `sum`.

## Operation

- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**, on `start`=1:
  - latch `op_a` into `a_sh` and `op_b` into `b_sh`;
  - set `carry` ← `cin` and `cnt` ← 0;
  - go to RUN.
- **IDLE**, on `start`=0: stay in IDLE.
- **RUN**, every cycle:
  - compute the full-adder result of `a_sh[0]`, `b_sh[0]` and `carry`, giving `s` and `c`;
  - shift `a_sh` and `b_sh` right by 1;
  - shift `s` into the MSB of `acc_sh` (acc_sh ← {s, acc_sh[WIDTH-1:1]});
  - set `carry` ← `c` and increment `cnt`.
- **RUN**, when `cnt` == WIDTH-1: in the same edge, load `sum` ← {s, acc_sh[WIDTH-1:1]} and `cout` ← `c`, then go to DONE.
- **DONE**: `done`=1 for exactly this one cycle, then unconditionally return to IDLE.
- `start` is ignored in RUN and DONE. There is no queueing, and operand changes during RUN have no effect.
- `sum` and `cout` change only on the RUN→DONE edge. `acc_sh` is internal and never drives `sum` directly.
- Arithmetic is pure binary and modulo 2^WIDTH. Overflow is reported only through `cout`.
- `cnt` width is $clog2(WIDTH). It must not wrap before reaching WIDTH-1.

## Timing

- **Reset:** `reset_L`=0 at an edge forces:
  - state IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - `a_sh`, `b_sh`, `acc_sh`, `carry` and `cnt` all = 0.
- **Reset mid-operation:** aborts with no `done` pulse, and `sum`/`cout` clear to 0.
- **Start acceptance:** `start` is sampled at edge E0 while in IDLE.
  - RUN occupies the cycles after E0 through E_WIDTH.
  - `busy` is high for exactly WIDTH cycles.
- **Completion:** `done` is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after the accepting edge.
  - For WIDTH=32, `done` is observed 33 cycles after start.
- **Throughput:** the earliest next accepted `start` is at the edge that ends the DONE cycle plus one, i.e. the first IDLE cycle.
  - One addition takes WIDTH+2 cycles.
- **Start held high:** if `start` stays high continuously, a new operation is accepted in each IDLE cycle. Back-to-back operations are separated by DONE and IDLE.
- **Output decode:** `busy` and `done` are registered-state decodes, with no combinational path from inputs. They are never high simultaneously.

## Structure

- **Shared package** (`serial_adder_pkg`):
  - state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - default width constant `HASH_WORD_W`=32.
- **Sub-module:** one full-adder slice, `fa_cell` (a, b, cin → s, cout), which is purely combinational.
  - It is instantiated once.
  - All sequencing, shifting and carry registration stay in `serial_adder_32`.

## Test plan

All scenarios use WIDTH=32.

- **Reset:** hold `reset_L`=0 for 3 cycles, then release, with no `start` → `sum`=0, `cout`=0, `busy`=0, `done`=0 throughout.
- **Small add:** `op_a`=0x00000001, `op_b`=0x00000001, `cin`=0, with a 1-cycle `start` → `busy` high for 32 cycles, then `done` pulses 33 cycles after start with `sum`=0x00000002, `cout`=0.
- **Wrap-around:** 0xFFFFFFFF + 0x00000001, `cin`=0 → `sum`=0x00000000, `cout`=1.
  - Then 0x7FFFFFFF + 0x00000000, `cin`=1 → `sum`=0x80000000, `cout`=0.
- **Hash constants:** 0x6A09E667 + 0xBB67AE85, `cin`=0 → `sum`=0x257194EC, `cout`=1.
  - `sum` keeps its previous value until the `done` cycle.
- **Ignored start:** start 0x00000010 + 0x00000020, then at cycle 5 of RUN pulse `start` with 0xFFFFFFFF + 0xFFFFFFFF → `sum`=0x00000030, `cout`=0, and only one `done` pulse.
- **Reset mid-RUN:** pull `reset_L` low at RUN cycle 10 → next edge gives IDLE, `busy`=0, `sum`=0, and no `done`.
  - A following start of 0x00000003 + 0x00000004 completes normally with `sum`=0x00000007.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial modular adder: FSM encoding and the
// default hash-word width.
package serial_adder_pkg;

  localparam int HASH_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_32_fa.sv
// Single full-adder slice; purely combinational, reused once per clock by the
// serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_32.sv
// Bit-serial modular adder: op_a + op_b + cin, one bit per clock, LSB first,
// with a start/busy/done handshake.
module serial_adder_32
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = HASH_WORD_W
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Only the upper WIDTH-1 result bits need storage; the newest bit joins
  // them combinationally in acc_nxt.
  logic [WIDTH-2:0] acc_sh;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             last_bit;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign acc_nxt  = {fa_s, acc_sh};
  assign last_bit = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          acc_sh <= acc_nxt[WIDTH-1:1];
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= acc_nxt;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_32.sv
// Bench for serial_adder_32: directed and random additions scored against a
// plain-arithmetic reference, with the monitor decoupled from stimulus.
module tb_serial_adder_32;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               due;
  } exp_t;

  logic             clk;
  logic             reset_L;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  exp_t             exp_q[$];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               n_issued = 0;
  int               n_done = 0;
  int               busy_cnt = 0;
  bit               rst_pend = 1'b1;
  bit               fin = 1'b0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_cout = 1'b0;

  serial_adder_32 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: all comparisons happen here, away from the active edge.
  always @(negedge clk) begin
    if (fin) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_results: %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (n_done != n_issued) begin
        errors++;
        $display("FAIL done_count: got %0d pulses, required %0d", n_done, n_issued);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (rst_pend) begin
      checks++;
      if (sum !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: sum=%h cout=%b busy=%b done=%b, required all 0",
                 sum, cout, busy, done);
      end
      exp_q.delete();
      busy_cnt  = 0;
      held_sum  = '0;
      held_cout = 1'b0;
    end else begin
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap: both high at cycle %0d", cyc);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done with no operation outstanding at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (sum !== e.sum || cout !== e.cout) begin
            errors++;
            $display("FAIL result: sum=%h cout=%b, required sum=%h cout=%b",
                     sum, cout, e.sum, e.cout);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, e.due);
          end
          checks++;
          if (busy_cnt != WIDTH) begin
            errors++;
            $display("FAIL busy_length: busy for %0d cycles, required %0d", busy_cnt, WIDTH);
          end
        end
        busy_cnt  = 0;
        held_sum  = sum;
        held_cout = cout;
      end else if (sum !== held_sum || cout !== held_cout) begin
        errors++;
        $display("FAIL output_hold: sum=%h cout=%b changed without done, required %h %b",
                 sum, cout, held_sum, held_cout);
      end
    end
    rst_pend = (reset_L == 1'b0);
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && done === 1'b0) break;
    end
  endtask

  // Issue one addition; ign_at pulses a stray start in that RUN cycle,
  // rst_at pulls reset low in that RUN cycle (0 disables either).
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int ign_at, input int rst_at);
    logic [WIDTH:0] r;
    int             edges;
    bit             got;
    wait_idle();
    r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
    exp_q.push_back('{r[WIDTH-1:0], r[WIDTH], cyc + WIDTH + 1});
    if (rst_at == 0) n_issued++;
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < WIDTH + 10) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        cin   = 1'($urandom);
      end
      if (ign_at != 0 && edges == ign_at) begin
        start = 1'b1;
        op_a  = '1;
        op_b  = '1;
      end
      if (ign_at != 0 && edges == ign_at + 1) start = 1'b0;
      if (rst_at != 0 && edges == rst_at) reset_L = 1'b0;
      if (rst_at != 0 && edges == rst_at + 1) begin
        reset_L = 1'b1;
        got     = 1'b1;
      end
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  initial begin
    reset_L = 1'b0;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    cin     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_L = 1'b1;
    repeat (4) @(posedge clk);

    do_add(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 0);
    do_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
    do_add(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0, 0);
    do_add(32'h6A09_E667, 32'hBB67_AE85, 1'b0, 0, 0);
    do_add(32'h0000_0010, 32'h0000_0020, 1'b0, 5, 0);
    do_add(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0, 10);
    repeat (WIDTH + 8) @(posedge clk);
    do_add(32'h0000_0003, 32'h0000_0004, 1'b0, 0, 0);
    do_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_add($urandom, $urandom, 1'($urandom), 0, 0);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1 fin = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
